// File: rtl/sel_mux_pkg.sv
// ---------------------------------------------------------------------------
// sel_mux_pkg
// Shared constants for the sel_mux slice: the smallest legal element count
// and element width. The select width itself is derived with $clog2 at the
// point of use, so no typedefs live here.
// ---------------------------------------------------------------------------
package sel_mux_pkg;

    // Smallest legal number of selectable elements.
    localparam int unsigned MIN_WIDTH = 2;

    // Smallest legal bit width of one element.
    localparam int unsigned MIN_DEPTH = 1;

endpackage : sel_mux_pkg

// File: rtl/sel_mux_if.sv
// ---------------------------------------------------------------------------
// sel_mux_if
// Bundles the data/select/enable inputs and the three results of sel_mux.
//   I_INPUT      : P_WIDTH packed elements, element 0 in the LSBs
//   I_SELECT     : binary index of the element to route
//   I_ENABLE     : load enable for the registered copy
//   O_OUTPUT     : combinational selected element
//   O_SEL_VALID  : combinational, 1 while I_SELECT < P_WIDTH
//   O_OUTPUT_REG : registered selected element
// master drives the inputs (the consumer side); slave is the mux itself.
// ---------------------------------------------------------------------------
interface sel_mux_if
    import sel_mux_pkg::*;
#(
    parameter int unsigned P_WIDTH = 2,
    parameter int unsigned P_DEPTH = 1
);

    localparam int unsigned L_SEL_W = $clog2(P_WIDTH);

    logic [P_WIDTH-1:0][P_DEPTH-1:0] I_INPUT;
    logic [L_SEL_W-1:0]              I_SELECT;
    logic                            I_ENABLE;
    logic [P_DEPTH-1:0]              O_OUTPUT;
    logic                            O_SEL_VALID;
    logic [P_DEPTH-1:0]              O_OUTPUT_REG;

    modport master (
        output I_INPUT,
        output I_SELECT,
        output I_ENABLE,
        input  O_OUTPUT,
        input  O_SEL_VALID,
        input  O_OUTPUT_REG
    );

    modport slave (
        input  I_INPUT,
        input  I_SELECT,
        input  I_ENABLE,
        output O_OUTPUT,
        output O_SEL_VALID,
        output O_OUTPUT_REG
    );

endinterface : sel_mux_if

// File: rtl/sel_mux_reg.sv
// ---------------------------------------------------------------------------
// sel_mux_reg
// Enabled output register with asynchronous active-high clear.
//   I_CLK    : clock, rising edge active
//   I_RESET  : asynchronous active-high clear of O_Q
//   I_ENABLE : load I_D on the rising edge when high, hold otherwise
//   I_D      : data to capture
//   O_Q      : registered data
// ---------------------------------------------------------------------------
module sel_mux_reg
    import sel_mux_pkg::*;
#(
    parameter int unsigned P_DEPTH = 1
) (
    input  logic               I_CLK,
    input  logic               I_RESET,
    input  logic               I_ENABLE,
    input  logic [P_DEPTH-1:0] I_D,
    output logic [P_DEPTH-1:0] O_Q
);

    if (P_DEPTH < MIN_DEPTH) begin : g_bad_depth
        $error("sel_mux_reg: P_DEPTH must be >= 1");
    end

    // Capture on enable; clear immediately on reset regardless of the clock.
    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            O_Q <= '0;
        end else if (I_ENABLE) begin
            O_Q <= I_D;
        end
    end

endmodule : sel_mux_reg

// File: rtl/sel_mux.sv
// ---------------------------------------------------------------------------
// sel_mux
// Parameterized N-to-1 multiplexer with a zero-latency combinational result
// and an optional registered copy for timing-critical consumers.
//   I_CLK   : clock for the registered copy, rising edge active
//   I_RESET : asynchronous active-high clear of the registered copy only
//   bus     : sel_mux_if slave modport carrying I_INPUT, I_SELECT, I_ENABLE,
//             O_OUTPUT, O_SEL_VALID and O_OUTPUT_REG
// An out-of-range select (only reachable for non power-of-two P_WIDTH)
// yields an all-zero element and drops O_SEL_VALID; the register loads that
// zero like any other value.
// ---------------------------------------------------------------------------
module sel_mux
    import sel_mux_pkg::*;
#(
    parameter int unsigned P_WIDTH = 2,
    parameter int unsigned P_DEPTH = 1
) (
    input  logic      I_CLK,
    input  logic      I_RESET,
    sel_mux_if.slave  bus
);

    localparam int unsigned L_SEL_W = $clog2(P_WIDTH);

    // Element count held one bit wider than the select so the range compare
    // is exact even when P_WIDTH is a power of two.
    localparam logic [L_SEL_W:0] L_COUNT = (L_SEL_W + 1)'(P_WIDTH);

    if (P_WIDTH < MIN_WIDTH) begin : g_bad_width
        $error("sel_mux: P_WIDTH must be >= 2");
    end

    if (P_DEPTH < MIN_DEPTH) begin : g_bad_depth
        $error("sel_mux: P_DEPTH must be >= 1");
    end

    logic [P_DEPTH-1:0] sel_data;
    logic               sel_valid;

    // Selector: one compare per element, so an unmatched select falls
    // through to the all-zero default without any out-of-range indexing.
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < P_WIDTH; i++) begin
            if (bus.I_SELECT == L_SEL_W'(i)) begin
                sel_data = bus.I_INPUT[i];
            end
        end
    end

    assign sel_valid = ({1'b0, bus.I_SELECT} < L_COUNT);

    assign bus.O_OUTPUT    = sel_data;
    assign bus.O_SEL_VALID = sel_valid;

    sel_mux_reg #(
        .P_DEPTH (P_DEPTH)
    ) u_reg (
        .I_CLK    (I_CLK),
        .I_RESET  (I_RESET),
        .I_ENABLE (bus.I_ENABLE),
        .I_D      (sel_data),
        .O_Q      (bus.O_OUTPUT_REG)
    );

endmodule : sel_mux

// File: tb/tb_sel_mux.sv
// ---------------------------------------------------------------------------
// tb_sel_mux
// Directed bench for sel_mux in three configurations: 16x1, 4x2 and 5x3.
// ---------------------------------------------------------------------------
module tb_sel_mux;

    logic clk;
    logic rst;

    int errors = 0;
    int checks = 0;

    sel_mux_if #(.P_WIDTH(16), .P_DEPTH(1)) bus_a ();
    sel_mux_if #(.P_WIDTH(4),  .P_DEPTH(2)) bus_b ();
    sel_mux_if #(.P_WIDTH(5),  .P_DEPTH(3)) bus_c ();

    sel_mux #(.P_WIDTH(16), .P_DEPTH(1)) dut_a (
        .I_CLK   (clk),
        .I_RESET (rst),
        .bus     (bus_a.slave)
    );

    sel_mux #(.P_WIDTH(4), .P_DEPTH(2)) dut_b (
        .I_CLK   (clk),
        .I_RESET (rst),
        .bus     (bus_b.slave)
    );

    sel_mux #(.P_WIDTH(5), .P_DEPTH(3)) dut_c (
        .I_CLK   (clk),
        .I_RESET (rst),
        .bus     (bus_c.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] pat;

        rst = 1'b1;
        bus_a.I_INPUT = '0; bus_a.I_SELECT = '0; bus_a.I_ENABLE = 1'b0;
        bus_b.I_INPUT = '0; bus_b.I_SELECT = '0; bus_b.I_ENABLE = 1'b0;
        bus_c.I_INPUT = '0; bus_c.I_SELECT = '0; bus_c.I_ENABLE = 1'b0;

        // Reset state of the registered copies (enable high to prove reset wins).
        bus_b.I_INPUT  = 8'hFF;
        bus_b.I_ENABLE = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_reg_a", 32'(bus_a.O_OUTPUT_REG), 32'd0);
        check("reset_reg_b", 32'(bus_b.O_OUTPUT_REG), 32'd0);
        check("reset_reg_c", 32'(bus_c.O_OUTPUT_REG), 32'd0);
        bus_b.I_ENABLE = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // 16x1 directed selects on A5C3.
        bus_a.I_INPUT = 16'hA5C3;
        bus_a.I_SELECT = 4'd0;  #1;
        check("a_sel0",    32'(bus_a.O_OUTPUT),    32'd1);
        check("a_valid0",  32'(bus_a.O_SEL_VALID), 32'd1);
        bus_a.I_SELECT = 4'd2;  #1;
        check("a_sel2",    32'(bus_a.O_OUTPUT),    32'd0);
        check("a_valid2",  32'(bus_a.O_SEL_VALID), 32'd1);
        bus_a.I_SELECT = 4'd6;  #1;
        check("a_sel6",    32'(bus_a.O_OUTPUT),    32'd1);
        check("a_valid6",  32'(bus_a.O_SEL_VALID), 32'd1);
        bus_a.I_SELECT = 4'd15; #1;
        check("a_sel15",   32'(bus_a.O_OUTPUT),    32'd1);
        check("a_valid15", 32'(bus_a.O_SEL_VALID), 32'd1);
        bus_a.I_SELECT = 4'd3;  #1;
        check("a_sel3",    32'(bus_a.O_OUTPUT),    32'd0);

        // Sweep the inputs with select 0; only bit 0 may reach the output.
        bus_a.I_SELECT = 4'd0;
        for (int v = 0; v <= 65535; v += 15) begin
            pat = 16'(v);
            bus_a.I_INPUT = pat;
            #1;
            check("a_sweep", 32'(bus_a.O_OUTPUT), 32'(pat[0]));
        end

        // 4x2 with element i = i.
        bus_b.I_INPUT = 8'b11_10_01_00;
        bus_b.I_SELECT = 2'd0; #1;
        check("b_sel0", 32'(bus_b.O_OUTPUT), 32'd0);
        bus_b.I_SELECT = 2'd1; #1;
        check("b_sel1", 32'(bus_b.O_OUTPUT), 32'd1);
        bus_b.I_SELECT = 2'd2; #1;
        check("b_sel2", 32'(bus_b.O_OUTPUT), 32'd2);
        bus_b.I_SELECT = 2'd3; #1;
        check("b_sel3", 32'(bus_b.O_OUTPUT), 32'd3);
        check("b_valid3", 32'(bus_b.O_SEL_VALID), 32'd1);

        // 5x3 with elements 1..5, including the out-of-range selects.
        bus_c.I_INPUT = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
        bus_c.I_SELECT = 3'd0; #1;
        check("c_sel0",   32'(bus_c.O_OUTPUT),    32'd1);
        bus_c.I_SELECT = 3'd4; #1;
        check("c_sel4",   32'(bus_c.O_OUTPUT),    32'd5);
        check("c_valid4", 32'(bus_c.O_SEL_VALID), 32'd1);
        bus_c.I_SELECT = 3'd5; #1;
        check("c_sel5",   32'(bus_c.O_OUTPUT),    32'd0);
        check("c_valid5", 32'(bus_c.O_SEL_VALID), 32'd0);
        bus_c.I_SELECT = 3'd6; #1;
        check("c_sel6",   32'(bus_c.O_OUTPUT),    32'd0);
        check("c_valid6", 32'(bus_c.O_SEL_VALID), 32'd0);
        bus_c.I_SELECT = 3'd7; #1;
        check("c_valid7", 32'(bus_c.O_SEL_VALID), 32'd0);

        // Registered path on 4x2: load select 3 one edge later.
        @(negedge clk);
        bus_b.I_ENABLE = 1'b1;
        bus_b.I_SELECT = 2'd3;
        #1;
        check("b_reg_before_edge", 32'(bus_b.O_OUTPUT_REG), 32'd0);
        @(posedge clk); #1;
        check("b_reg_load3", 32'(bus_b.O_OUTPUT_REG), 32'd3);

        // Enable low: hold 3 while the combinational result follows select 1.
        @(negedge clk);
        bus_b.I_ENABLE = 1'b0;
        bus_b.I_SELECT = 2'd1;
        @(posedge clk); #1;
        check("b_reg_hold", 32'(bus_b.O_OUTPUT_REG), 32'd3);
        check("b_out_sel1", 32'(bus_b.O_OUTPUT),     32'd1);

        // Reset pulse between edges clears only the register.
        #2;
        rst = 1'b1;
        #1;
        check("b_reg_async_clr", 32'(bus_b.O_OUTPUT_REG), 32'd0);
        check("b_out_in_reset",  32'(bus_b.O_OUTPUT),     32'd1);
        check("b_valid_in_reset", 32'(bus_b.O_SEL_VALID), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        check("b_reg_after_clr", 32'(bus_b.O_OUTPUT_REG), 32'd0);

        // Reload after reset.
        @(negedge clk);
        bus_b.I_ENABLE = 1'b1;
        bus_b.I_SELECT = 2'd2;
        @(posedge clk); #1;
        check("b_reg_load2", 32'(bus_b.O_OUTPUT_REG), 32'd2);

        // 5x3 registered: valid element then out-of-range zero.
        @(negedge clk);
        bus_c.I_ENABLE = 1'b1;
        bus_c.I_SELECT = 3'd4;
        @(posedge clk); #1;
        check("c_reg_load5", 32'(bus_c.O_OUTPUT_REG), 32'd5);
        @(negedge clk);
        bus_c.I_SELECT = 3'd6;
        @(posedge clk); #1;
        check("c_reg_oor", 32'(bus_c.O_OUTPUT_REG), 32'd0);

        // 16x1 registered copy tracks a single-bit element.
        @(negedge clk);
        bus_a.I_INPUT  = 16'hA5C3;
        bus_a.I_SELECT = 4'd7;
        bus_a.I_ENABLE = 1'b1;
        @(posedge clk); #1;
        check("a_reg_sel7", 32'(bus_a.O_OUTPUT_REG), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_sel_mux

// File: doc/sel_mux.md
Name: sel_mux

Overview:
- Parameterized N-to-1 multiplexer. Selects one of P_WIDTH input elements, each P_DEPTH bits wide, using a binary select.
- Provides two outputs:
  - a purely combinational result, used by the datapath (register-file read ports, ALU operand and writeback selection);
  - an optional registered copy, for timing-critical consumers.
- Single clock domain.

Parameters:
- P_WIDTH, default 2: number of selectable input elements; must be ≥ 2.
- P_DEPTH, default 1: bit width of each element and of the output; must be ≥ 1.
- L_SEL_W, localparam: select width, fixed at $clog2(P_WIDTH). Not user-overridable.

Ports:
- I_CLK, input, 1: system clock. Rising edge active.
- I_RESET, input, 1: reset for the registered stage. Asynchronous, active-high.
- I_INPUT, input, [P_WIDTH-1:0][P_DEPTH-1:0]: packed input elements. Element 0 occupies the least-significant P_DEPTH bits.
- I_SELECT, input, L_SEL_W: binary index of the element to route.
- I_ENABLE, input, 1: load enable for the registered output.
- O_OUTPUT, output, P_DEPTH: combinational selected element.
- O_SEL_VALID, output, 1: combinational flag; 1 when I_SELECT < P_WIDTH.
- O_OUTPUT_REG, output, P_DEPTH: registered selected element.

Behaviour:
- O_OUTPUT = I_INPUT[I_SELECT], zero latency, purely combinational.
  - No clock or reset dependence.
  - Must settle within the same simulation timestep as an input or select change.
  - No latches.
- Out-of-range select (possible only when P_WIDTH is not a power of two and I_SELECT ≥ P_WIDTH):
  - O_OUTPUT = all zeros;
  - O_SEL_VALID = 0.
  - Otherwise O_SEL_VALID = 1.
- X/Z on I_SELECT need not be handled specially; simulation propagates X.
- O_OUTPUT_REG:
  - I_RESET high clears it to 0 immediately (asynchronous), regardless of clock.
  - On a rising edge of I_CLK with I_RESET low and I_ENABLE = 1, it loads the current O_OUTPUT value, including zero for an out-of-range select.
  - With I_ENABLE = 0, it holds its value.
  - Latency: one cycle from select or input change to O_OUTPUT_REG.
- Reset mid-operation clears only O_OUTPUT_REG. O_OUTPUT and O_SEL_VALID keep tracking their inputs.
- Reset deassertion takes effect at the next rising edge; the first load occurs on that edge if I_ENABLE = 1.
- Every element is independently addressable. A change to one element affects O_OUTPUT only while that element is selected.
- Elaboration-time assertions:
  - P_WIDTH < 2 is an error;
  - P_DEPTH < 1 is an error.

Decomposition:
- Shared package: no new typedefs. The select-width computation uses $clog2 directly.
- The combinational selector is the core and stays inline.
- The output register is a natural sub-module: sel_mux_reg.
  - Parameter: P_DEPTH.
  - Ports: I_CLK, I_RESET, I_ENABLE, I_D, O_Q.
  - Async active-high clear.

Test Plan:
- P_WIDTH=16, P_DEPTH=1, I_INPUT=16'hA5C3:
  - select 0 → O_OUTPUT=1;
  - select 2 → 0;
  - select 6 → 1;
  - select 15 → 1;
  - O_SEL_VALID=1 throughout.
- P_WIDTH=16, P_DEPTH=1, select 0, sweep I_INPUT from 0 to 65535 in steps of 15 → O_OUTPUT equals I_INPUT[0] after each step, with no clock.
- P_WIDTH=4, P_DEPTH=2, element i = i[1:0], select 0 to 3 → O_OUTPUT = 2'b00, 01, 10, 11 respectively.
- P_WIDTH=5, P_DEPTH=3, elements = 1..5:
  - select 4 → O_OUTPUT=5, O_SEL_VALID=1;
  - select 6 → O_OUTPUT=0, O_SEL_VALID=0.
- P_WIDTH=4, P_DEPTH=2, registered path:
  - I_ENABLE=1, select 3 → O_OUTPUT_REG=2'b11 one edge later;
  - I_ENABLE=0, select 1 → holds 2'b11;
  - pulse I_RESET between edges → O_OUTPUT_REG=0 immediately, while O_OUTPUT stays 2'b01.
